// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared state encoding and instruction-memory base address.
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CKSUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Also the fetch unit's reset PC.
    localparam logic [31:0] c_im_base_addr = 32'h0000_3000;

endpackage : im_loader_pkg
`default_nettype wire

// File: rtl/im_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : im_word_packer
// Description : Packs accepted bytes big-endian into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module im_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // The word is complete combinationally on the 4th accepted byte.
    assign word_valid = take && (r_cnt == 2'd3);
    assign word       = {r_shift, byte_data};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (take) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], byte_data};
        end
    end

endmodule : im_word_packer
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Byte-stream instruction-memory loader; holds the core while
//               loading. Optional checksum trailer via IM_LOADER_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = c_im_base_addr
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       last_pc,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_next;
    logic              w_take;
    logic              w_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
`ifdef IM_LOADER_CKSUM_EN
    logic [31:0]       r_sum;
`endif

    assign w_take     = byte_valid && byte_ready;
    assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_idx_next = r_idx + c_one;

    im_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .take       (w_take),
        .byte_data  (byte_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= 32'd0;
            last_pc    <= BASE_ADDR;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            im_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_len <= load_len;
                        r_idx <= '0;
                        error <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
                        r_sum <= 32'd0;
`endif
                        if (load_len == '0) begin
`ifdef IM_LOADER_CKSUM_EN
                            // Empty image still carries a (zero) checksum.
                            r_state    <= S_CKSUM;
                            byte_ready <= 1'b1;
                            cpu_hold   <= 1'b1;
                            done       <= 1'b0;
`else
                            r_state    <= S_DONE;
                            done       <= 1'b1;
`endif
                        end else if (load_len > c_max_len) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            r_state    <= S_RECV;
                            byte_ready <= 1'b1;
                            cpu_hold   <= 1'b1;
                            done       <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    if (w_word_valid) begin
                        r_state    <= S_WRITE;
                        byte_ready <= 1'b0;
                        im_we      <= 1'b1;
                        im_addr    <= r_idx[ADDR_W-1:0];
                        im_wdata   <= w_word;
                    end
                end
                S_WRITE: begin
                    last_pc <= BASE_ADDR + (32'(im_addr) << 2);
                    r_idx   <= w_idx_next;
`ifdef IM_LOADER_CKSUM_EN
                    r_sum   <= r_sum + im_wdata;
`endif
                    if (w_idx_next == r_len) begin
`ifdef IM_LOADER_CKSUM_EN
                        r_state    <= S_CKSUM;
                        byte_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
`endif
                    end else begin
                        r_state    <= S_RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef IM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (w_word_valid) begin
                        r_state    <= S_DONE;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                        done       <= 1'b1;
                        error      <= (w_word != r_sum);
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule : im_loader
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader (table, hand and random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic [31:0] last_pc;
    logic        cpu_hold;
    logic        done;
    logic        error;

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .last_pc    (last_pc),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  stim[$];
    logic [11:0] mon_addr[$];
    logic [31:0] mon_data[$];
    logic [31:0] exp_words[$];

    // Every write strobe seen mid-cycle is one memory write.
    always @(negedge clk) begin
        if (!reset && im_we) begin
            mon_addr.push_back(im_addr);
            mon_data.push_back(im_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] sum_words();
        logic [31:0] s = 32'd0;
        foreach (exp_words[k]) s = s + exp_words[k];
        return s;
    endfunction

    task automatic do_start(input int len);
        mon_addr.delete();
        mon_data.delete();
        load_len = 13'(len);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // mode 0: always valid, 1: every other cycle, 2: random
    task automatic feed(input int mode);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < stim.size() && budget < 4000) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (budget % 2 == 1);
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_data = stim[i];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
            budget++;
        end
        byte_valid = 1'b0;
        if (i < stim.size()) chk("feed_timeout", 32'(i), 32'(stim.size()));
    endtask

    task automatic wait_done();
        int c = 0;
        @(negedge clk);
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("hold_at_done", 32'(cpu_hold), 32'd0);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 32'(mon_data.size()), 32'(exp_words.size()));
        for (int k = 0; k < exp_words.size() && k < mon_data.size(); k++) begin
            chk({tag, "_addr"}, 32'(mon_addr[k]), 32'(k));
            chk({tag, "_data"}, mon_data[k], exp_words[k]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(im_we), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_addr"}, 32'(im_addr), 32'd0);
        chk({tag, "_wdata"}, im_wdata, 32'd0);
        chk({tag, "_pc"}, last_pc, 32'h0000_3000);
    endtask

    typedef struct {
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          mode;
        bit          exp_err;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int len;
        logic [31:0] w;

        tbl[0] = '{2,    32'h8D4C_0000, 32'h240A_0001, 0, 1'b0, 32'h0000_3004};
        tbl[1] = '{2,    32'h8D4C_0000, 32'h240A_0001, 1, 1'b0, 32'h0000_3004};
        tbl[2] = '{0,    32'h0,         32'h0,         0, 1'b0, 32'h0000_3004};
        tbl[3] = '{4097, 32'h0,         32'h0,         0, 1'b1, 32'h0000_3004};
        tbl[4] = '{1,    32'hDEAD_BEEF, 32'h0,         2, 1'b0, 32'h0000_3000};

        reset = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            stim.delete();
            exp_words.delete();
            if (tbl[t].len >= 1 && tbl[t].len <= 4096) exp_words.push_back(tbl[t].w0);
            if (tbl[t].len >= 2 && tbl[t].len <= 4096) exp_words.push_back(tbl[t].w1);
            foreach (exp_words[k]) push_word(exp_words[k]);
`ifdef IM_LOADER_CKSUM_EN
            if (tbl[t].len <= 4096) push_word(sum_words());
`endif
            do_start(tbl[t].len);
            feed(tbl[t].mode);
            wait_done();
            chk_writes($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_err", t), 32'(error), 32'(tbl[t].exp_err));
            chk($sformatf("tbl%0d_pc", t), last_pc, tbl[t].exp_pc);
        end

        // Cycle-accurate one-word load: start, write strobe and done timing.
        mon_addr.delete(); mon_data.delete();
        do_start(1);
        chk("t_start_hold", 32'(cpu_hold), 32'd1);
        chk("t_start_ready", 32'(byte_ready), 32'd1);
        chk("t_start_done", 32'(done), 32'd0);
        w = 32'hA1B2_C3D4;
        for (int b = 0; b < 4; b++) begin
            byte_valid = 1'b1;
            byte_data  = w[31 - 8*b -: 8];
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        chk("t_we_hi", 32'(im_we), 32'd1);
        chk("t_we_addr", 32'(im_addr), 32'd0);
        chk("t_we_data", im_wdata, 32'hA1B2_C3D4);
        chk("t_we_ready", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;
        chk("t_we_lo", 32'(im_we), 32'd0);
`ifdef IM_LOADER_CKSUM_EN
        chk("t_ck_hold", 32'(cpu_hold), 32'd1);
        stim.delete();
        push_word(32'hA1B2_C3D4);
        feed(0);
        @(negedge clk);
`endif
        chk("t_done", 32'(done), 32'd1);
        chk("t_hold_lo", 32'(cpu_hold), 32'd0);
        chk("t_pc", last_pc, 32'h0000_3000);

        // Reset after 6 of 8 bytes; the partial word must not leak.
        stim.delete();
        push_word(32'h0102_0304);
        push_word(32'h0506_0708);
        void'(stim.pop_back());
        void'(stim.pop_back());
        do_start(2);
        feed(0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("mid");
        reset = 1'b0;
        stim.delete();
        exp_words.delete();
        exp_words.push_back(32'h1122_3344);
        push_word(32'h1122_3344);
`ifdef IM_LOADER_CKSUM_EN
        push_word(32'h1122_3344);
`endif
        do_start(1);
        feed(0);
        wait_done();
        chk_writes("mid_new");
        chk("mid_new_err", 32'(error), 32'd0);

        // Random loads against the word-list model.
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 6));
            stim.delete();
            exp_words.delete();
            for (int k = 0; k < len; k++) exp_words.push_back($urandom);
            foreach (exp_words[k]) push_word(exp_words[k]);
`ifdef IM_LOADER_CKSUM_EN
            push_word(sum_words());
`endif
            do_start(len);
            feed(2);
            wait_done();
            chk_writes($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_err", r), 32'(error), 32'd0);
            chk($sformatf("rnd%0d_pc", r), last_pc, 32'h0000_3000 + 32'(4 * (len - 1)));
        end

`ifdef IM_LOADER_CKSUM_EN
        for (int c = 0; c < 2; c++) begin
            stim.delete();
            exp_words.delete();
            exp_words.push_back(32'h0000_0001);
            exp_words.push_back(32'hFFFF_FFFF);
            foreach (exp_words[k]) push_word(exp_words[k]);
            push_word(32'(c));
            do_start(2);
            feed(0);
            wait_done();
            chk_writes($sformatf("ck%0d", c));
            chk($sformatf("ck%0d_err", c), 32'(error), 32'(c));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_im_loader
`default_nettype wire
